// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset clear sweep, highest-port-wins write priority,
// full write-to-read bypass and a registered multi-writer conflict flag.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 4,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*AW-1:0]     waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic                     ready,
    output logic                     wr_conflict
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              wr_conflict_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     raddr_s [NUM_RD];
    logic [DATA_W-1:0] rdata_s [NUM_RD];
    logic [AW-1:0]     waddr_s [NUM_WR];
    logic [DATA_W-1:0] wdata_s [NUM_WR];
    logic [NUM_WR-1:0] eff_s;
    logic              conflict_s;
    logic              ready_s;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        addr_ok = (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign raddr_s[i] = raddr[i*AW +: AW];
        assign rdata[i*DATA_W +: DATA_W] = rdata_s[i];
    end

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign waddr_s[j] = waddr[j*AW +: AW];
        assign wdata_s[j] = wdata[j*DATA_W +: DATA_W];
    end

    assign ready_s     = (state_q == ST_READY);
    assign ready       = ready_s;
    assign wr_conflict = wr_conflict_q;

    // Clear-sweep sequencing: one register per edge, then park in READY
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Effective-write qualification and same-address detection across write ports
    always_comb begin
        eff_s      = '0;
        conflict_s = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (ready_s && we[j] && addr_ok(waddr_s[j])) begin
                eff_s[j] = 1'b1;
            end else begin
                eff_s[j] = 1'b0;
            end
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (eff_s[j] && eff_s[k] && (waddr_s[j] == waddr_s[k])) begin
                    conflict_s = 1'b1;
                end else begin
                    conflict_s = conflict_s;
                end
            end
        end
    end

    // Read ports: later write ports override earlier ones in the bypass scan
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdata_s[i] = '0;
            if (ready_s && addr_ok(raddr_s[i])) begin
                rdata_s[i] = mem_q[raddr_s[i]];
                for (int j = 0; j < NUM_WR; j++) begin
                    if (BYPASS && eff_s[j] && (waddr_s[j] == raddr_s[i])) begin
                        rdata_s[i] = wdata_s[j];
                    end else begin
                        rdata_s[i] = rdata_s[i];
                    end
                end
            end else begin
                rdata_s[i] = '0;
            end
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            wr_conflict_q <= conflict_s;
        end
    end

    // Storage array: cleared by the sweep, no reset of its own
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (eff_s[j]) begin
                        mem_q[waddr_s[j]] <= wdata_s[j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp: three instances (default, no bypass, depth 24)
// share one stimulus stream and are compared to a per-instance reference model.
module tb_regfile_mp;

    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int AWB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NRD*AWB-1:0]   raddr;
    logic [NWR-1:0]       we;
    logic [NWR*AWB-1:0]   waddr;
    logic [NWR*32-1:0]    wdata;
    logic [NRD*32-1:0]    rdata_w [3];
    logic                 ready_w [3];
    logic                 conf_w  [3];

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_w[0]), .we(we),
        .waddr(waddr), .wdata(wdata), .ready(ready_w[0]), .wr_conflict(conf_w[0])
    );

    regfile_mp #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_w[1]), .we(we),
        .waddr(waddr), .wdata(wdata), .ready(ready_w[1]), .wr_conflict(conf_w[1])
    );

    regfile_mp #(.DEPTH(24)) u_d24 (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_w[2]), .we(we),
        .waddr(waddr), .wdata(wdata), .ready(ready_w[2]), .wr_conflict(conf_w[2])
    );

    int          dep [3] = '{32, 32, 24};
    bit          byp [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mmem [3][32];
    int          cnt [3];
    logic        mconf [3];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    function automatic bit m_ready(int k);
        return cnt[k] >= dep[k];
    endfunction

    function automatic bit w_eff(int k, int j);
        logic [4:0] a;
        a = waddr[j*AWB +: AWB];
        return m_ready(k) && we[j] && (int'(a) < dep[k]) && (a != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(int k, logic [4:0] a);
        logic [31:0] r;
        if (!m_ready(k) || int'(a) >= dep[k] || a == 5'd0) return 32'h0;
        r = mmem[k][a];
        if (byp[k]) begin
            for (int j = 0; j < NWR; j++)
                if (w_eff(k, j) && waddr[j*AWB +: AWB] == a) r = wdata[j*32 +: 32];
        end
        return r;
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NRD; i++)
                check_eq($sformatf("u%0d_rd%0d", k, i), rdata_w[k][i*32 +: 32],
                         exp_read(k, raddr[i*AWB +: AWB]));
            check_eq($sformatf("u%0d_ready", k), {31'd0, ready_w[k]}, {31'd0, m_ready(k)});
            check_eq($sformatf("u%0d_conflict", k), {31'd0, conf_w[k]}, {31'd0, mconf[k]});
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                cnt[k]   = 0;
                mconf[k] = 1'b0;
                for (int r = 0; r < 32; r++) mmem[k][r] = 32'h0;
            end else begin
                logic c;
                c = 1'b0;
                for (int j = 0; j < NWR; j++)
                    for (int j2 = j + 1; j2 < NWR; j2++)
                        if (w_eff(k, j) && w_eff(k, j2) &&
                            waddr[j*AWB +: AWB] == waddr[j2*AWB +: AWB]) c = 1'b1;
                for (int j = 0; j < NWR; j++)
                    if (w_eff(k, j)) mmem[k][waddr[j*AWB +: AWB]] = wdata[j*32 +: 32];
                mconf[k] = c;
                if (cnt[k] < dep[k]) cnt[k]++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        we    = '0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
    endtask

    task automatic set_wr(input int j, input logic [4:0] a, input logic [31:0] d);
        we[j]              = 1'b1;
        waddr[j*AWB +: AWB] = a;
        wdata[j*32 +: 32]   = d;
    endtask

    task automatic set_rd_all(input logic [4:0] a);
        raddr = {NRD{a}};
    endtask

    initial begin
        int first0;
        int first2;
        rst = 1'b1;
        set_idle();
        for (int k = 0; k < 3; k++) begin
            cnt[k]   = 0;
            mconf[k] = 1'b0;
        end
        @(posedge clk);
        model_edge();
        #1;
        repeat (2) cycle();
        rst = 1'b0;

        // Clear sweep timing for both depths
        for (int e = 1; e <= 32; e++) begin
            cycle();
            check_eq("clr_rdy32", {31'd0, ready_w[0]}, (e >= 32) ? 32'd1 : 32'd0);
            check_eq("clr_rdy24", {31'd0, ready_w[2]}, (e >= 24) ? 32'd1 : 32'd0);
        end
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < NRD; i++) raddr[i*AWB +: AWB] = 5'(b*4 + i);
            #1;
            for (int i = 0; i < NRD; i++) check_eq("clr_zero", rdata_w[0][i*32 +: 32], 32'h0);
            cycle();
        end

        // Basic write then read on all ports
        set_idle();
        set_wr(0, 5'd5, 32'hDEADBEEF);
        cycle();
        set_idle();
        set_rd_all(5'd5);
        #1;
        for (int i = 0; i < NRD; i++) check_eq("r5_read", rdata_w[0][i*32 +: 32], 32'hDEADBEEF);
        cycle();

        // Two writers on one address: highest port wins, conflict pulses once
        set_wr(0, 5'd7, 32'h11111111);
        set_wr(1, 5'd7, 32'h22222222);
        cycle();
        set_idle();
        set_rd_all(5'd7);
        #1;
        check_eq("r7_prio", rdata_w[0][0 +: 32], 32'h22222222);
        check_eq("conf_set", {31'd0, conf_w[0]}, 32'd1);
        cycle();
        check_eq("conf_clr", {31'd0, conf_w[0]}, 32'd0);

        // Bypass vs. no bypass
        set_idle();
        set_wr(1, 5'd9, 32'hCAFEF00D);
        raddr[3*AWB +: AWB] = 5'd9;
        #1;
        check_eq("byp_on", rdata_w[0][3*32 +: 32], 32'hCAFEF00D);
        check_eq("byp_off_old", rdata_w[1][3*32 +: 32], 32'h0);
        cycle();
        set_idle();
        raddr[3*AWB +: AWB] = 5'd9;
        #1;
        check_eq("byp_off_new", rdata_w[1][3*32 +: 32], 32'hCAFEF00D);
        cycle();

        // Writes to register zero are dropped and never bypassed
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        set_wr(1, 5'd0, 32'h00001234);
        set_rd_all(5'd0);
        #1;
        check_eq("r0_same", rdata_w[0][0 +: 32], 32'h0);
        cycle();
        set_idle();
        #1;
        check_eq("r0_after", rdata_w[0][0 +: 32], 32'h0);
        check_eq("r0_noconf", {31'd0, conf_w[0]}, 32'd0);
        cycle();

        // Out-of-range accesses on the depth-24 instance
        set_wr(0, 5'd30, 32'h5);
        set_rd_all(5'd27);
        #1;
        check_eq("d24_rd27", rdata_w[2][0 +: 32], 32'h0);
        cycle();
        set_idle();
        set_rd_all(5'd30);
        #1;
        check_eq("d24_rd30", rdata_w[2][0 +: 32], 32'h0);
        check_eq("d32_rd30", rdata_w[0][0 +: 32], 32'h5);
        cycle();

        // Random traffic, addresses biased low to provoke collisions and bypass hits
        for (int n = 0; n < 400; n++) begin
            we = 2'($urandom);
            for (int j = 0; j < NWR; j++) begin
                waddr[j*AWB +: AWB] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                                                   : 5'($urandom_range(0, 31));
                wdata[j*32 +: 32] = $urandom;
            end
            for (int i = 0; i < NRD; i++)
                raddr[i*AWB +: AWB] = ($urandom_range(0, 2) == 0)
                    ? waddr[($urandom_range(0, 1))*AWB +: AWB] : 5'($urandom_range(0, 31));
            cycle();
        end

        // Reset in the middle of the clear sweep restarts the whole sweep
        set_idle();
        set_wr(0, 5'd3, 32'hAA);
        cycle();
        set_idle();
        set_rd_all(5'd3);
        #1;
        check_eq("r3_pre", rdata_w[0][0 +: 32], 32'hAA);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (9) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        first0 = -1;
        first2 = -1;
        for (int e = 1; e <= 40; e++) begin
            cycle();
            if (ready_w[0] && first0 < 0) first0 = e;
            if (ready_w[2] && first2 < 0) first2 = e;
        end
        check_eq("rdy_lat32", 32'(first0), 32'd32);
        check_eq("rdy_lat24", 32'(first2), 32'd24);
        set_rd_all(5'd3);
        #1;
        check_eq("r3_cleared", rdata_w[0][0 +: 32], 32'h0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
